// File: rtl/serving_uart_tx.sv
// Transmit-only 8N1 UART on a Wishbone slave port: byte FIFO, serializer, status register.
// Optional interrupt output and enable bit built in with `define SERVING_UART_TX_IRQ_EN.
module serving_uart_tx #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
`ifdef SERVING_UART_TX_IRQ_EN
  output logic        o_irq,
`endif
  output logic        o_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_LD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ack_q;
  logic [31:0]   rdt_q, rdt_d, status_w;
  state_t        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q;
`ifdef SERVING_UART_TX_IRQ_EN
  logic          irq_en_q, irq_q;
`endif

  logic req, push_req, stat_rd, empty, full, bit_end, pop, push, busy;

  // Only the first strobe cycle is a request; the ack cycle must not repeat side effects.
  assign req      = i_wb_stb & ~ack_q;
  assign push_req = req & i_wb_we & ~i_wb_adr & i_wb_sel[0];
  assign stat_rd  = req & ~i_wb_we & i_wb_adr;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign bit_end  = (baud_q == '0);
  assign busy     = (state_q != IDLE);
  assign pop      = ~empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign push     = push_req & (~full | pop);

  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // A drop in the same cycle as a clearing read keeps the flag set.
    ovf_d = ovf_q;
    if (stat_rd)            ovf_d = 1'b0;
    if (push_req && !push)  ovf_d = 1'b1;
    status_w    = '0;
    status_w[0] = busy;
    status_w[1] = full;
    status_w[2] = empty;
    status_w[3] = ovf_q;
`ifdef SERVING_UART_TX_IRQ_EN
    status_w[4]       = irq_en_q;
    status_w[8 +: CW] = cnt_q;
`else
    status_w[4 +: CW] = cnt_q;
`endif
    rdt_d = stat_rd ? status_w : '0;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= i_wb_dat[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q  <= 1'b0;
      rdt_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      ack_q <= req;
      rdt_q <= rdt_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          sh_q    <= mem_q[rptr_q];
          baud_q  <= BAUD_LD;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: if (bit_end) begin
          baud_q  <= BAUD_LD;
          bit_q   <= '0;
          tx_q    <= sh_q[0];
          state_q <= DATA;
        end else baud_q <= baud_q - 16'd1;
        DATA: if (bit_end) begin
          baud_q <= BAUD_LD;
          if (bit_q == 3'd7) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            bit_q <= bit_q + 3'd1;
            sh_q  <= sh_q >> 1;
            tx_q  <= sh_q[1];
          end
        end else baud_q <= baud_q - 16'd1;
        STOP: if (bit_end) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (pop) begin
            sh_q    <= mem_q[rptr_q];
            baud_q  <= BAUD_LD;
            tx_q    <= 1'b0;
            state_q <= START;
          end else state_q <= IDLE;
        end else baud_q <= baud_q - 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERVING_UART_TX_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (req && i_wb_we && i_wb_adr && i_wb_sel[0]) irq_en_q <= i_wb_dat[0];
      irq_q <= irq_en_q & empty & ~busy;
    end
  end
  assign o_irq = irq_q;
`endif

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_tx     = tx_q;
endmodule

// File: tb/tb_serving_uart_tx.sv
// Scoreboard bench: bus accesses and decoded UART frames are checked against a timing model.
`timescale 1ns/1ps
module tb_serving_uart_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0, rst = 1'b1;
  logic        adr = 1'b0, we = 1'b0, stb = 1'b0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] rdt;
  logic        ack, tx;
`ifdef SERVING_UART_TX_IRQ_EN
  logic        irq;
`endif

  serving_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack),
`ifdef SERVING_UART_TX_IRQ_EN
    .o_irq(irq),
`endif
    .o_tx(tx));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: each accepted byte has a push edge and a pop edge; a frame
  // occupies FRAME cycles after its pop edge and the next pop can't precede its end.
  typedef struct { logic [7:0] b; int p; } frm_t;
  int          acc_push[$], acc_pop[$];
  int          last_pop = -1000000;
  bit          ovf_m = 0, irq_en_m = 0;
  frm_t        sb_frm[$];
  logic [31:0] sb_rdt[$];

  function automatic int cnt_before(int e);
    int n = 0;
    foreach (acc_push[i]) if (acc_push[i] < e) n++;
    foreach (acc_pop[i])  if (acc_pop[i] < e)  n--;
    return n;
  endfunction
  function automatic bit pop_at(int e);
    foreach (acc_pop[i]) if (acc_pop[i] == e) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit busy_at(int e);
    foreach (acc_pop[i]) if (acc_pop[i] < e && e <= acc_pop[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] status_m(int e);
    int c = cnt_before(e);
    logic [31:0] v = '0;
    v[0] = busy_at(e); v[1] = (c == DEPTH); v[2] = (c == 0); v[3] = ovf_m;
`ifdef SERVING_UART_TX_IRQ_EN
    v[4] = irq_en_m;
    v = v | (32'(c) << 8);
`else
    v = v | (32'(c) << 4);
`endif
    return v;
  endfunction

  // Called just after a rising edge; the request is sampled on the next edge.
  task automatic bus(bit w, bit a, logic [31:0] d, logic [3:0] s, bit hold = 1'b0);
    int e, n, p;
    logic [31:0] exp_r;
    frm_t f;
    e = cyc + 1;
    exp_r = '0;
    if (w && !a && s[0]) begin
      if (cnt_before(e) < DEPTH || pop_at(e)) begin
        p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
        last_pop = p;
        acc_push.push_back(e);
        acc_pop.push_back(p);
        f.b = d[7:0]; f.p = p;
        sb_frm.push_back(f);
      end else ovf_m = 1'b1;
    end else if (!w && a) begin
      exp_r = status_m(e);
      ovf_m = 1'b0;
    end
`ifdef SERVING_UART_TX_IRQ_EN
    else if (w && a && s[0]) irq_en_m = d[0];
`endif
    sb_rdt.push_back(exp_r);
    adr = a; dat = d; sel = s; we = w; stb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 4);
    check("ack_latency", 32'(n), 32'd1);
    if (hold) begin @(posedge clk); #1; end
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_push.delete(); acc_pop.delete(); sb_frm.delete();
    last_pop = -1000000; ovf_m = 1'b0; irq_en_m = 1'b0;
    check("tx_after_reset", 32'(tx), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb_frm.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_done", 32'(sb_frm.size()), 32'd0);
    idle(DIV + 2);
  endtask

  // Bus monitor: every ack pops one expected read value; ack is a one-cycle pulse.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ack) begin
        if (sb_rdt.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else check("rdt", rdt, sb_rdt.pop_front());
        check("ack_pulse", 32'(prev_ack), 32'd0);
      end else if (rdt !== '0) check("rdt_idle", rdt, 32'd0);
    end
    prev_ack = ack;
  end

  // Line monitor: mid-bit sampling receiver, compared against expected frames.
  bit         rx_on = 1'b0, rx_st;
  int         rx_t0, rx_off;
  logic [7:0] rx_b;
  frm_t       rx_f;
  always @(negedge clk) begin
    if (rst) rx_on = 1'b0;
    else if (!rx_on) begin
      if (tx === 1'b0) begin rx_on = 1'b1; rx_t0 = cyc; rx_b = '0; end
    end else begin
      rx_off = cyc - rx_t0;
      if (rx_off % DIV == DIV / 2) begin
        if (rx_off / DIV == 0) rx_st = tx;
        else if (rx_off / DIV <= 8) rx_b[rx_off / DIV - 1] = tx;
        else begin
          rx_on = 1'b0;
          if (sb_frm.size() == 0) check("spurious_frame", 32'd1, 32'd0);
          else begin
            rx_f = sb_frm.pop_front();
            check("frame_byte", 32'(rx_b), 32'(rx_f.b));
            check("frame_start", 32'(rx_t0), 32'(rx_f.p));
            check("frame_start_stop", {30'd0, rx_st, tx}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rdt", rdt, 32'd0);
    bus(0, 1, 0, 4'hf);                    // status after reset: empty
    bus(1, 0, 32'hA5, 4'h1);
    idle(10);
    bus(0, 1, 0, 4'hf);                    // busy mid-frame
    drain();
    bus(1, 0, 32'h01, 4'h1);
    bus(1, 0, 32'h02, 4'h1);
    bus(1, 0, 32'h03, 4'h1);
    bus(0, 1, 0, 4'hf);                    // count 2 during first frame
    drain();
    for (int i = 0; i < 6; i++) bus(1, 0, 32'h10 + 32'(i), 4'h1);
    bus(0, 1, 0, 4'hf);                    // full, overflow
    bus(0, 1, 0, 4'hf);                    // overflow cleared
    drain();
    bus(1, 0, 32'h5C, 4'h1, 1'b1);         // held strobe: single push
    bus(1, 0, 32'h77, 4'he);               // sel[0]=0: no push
    bus(0, 0, 0, 4'hf);                    // DATA read returns 0
    bus(0, 1, 0, 4'hf);
    drain();
`ifdef SERVING_UART_TX_IRQ_EN
    bus(1, 1, 32'h1, 4'h1);
    idle(3);
    check("irq_idle_en", 32'(irq), 32'd1);
    bus(1, 0, 32'h3E, 4'h1);
    idle(5 * DIV);
    check("irq_in_frame", 32'(irq), 32'd0);
    drain();
    check("irq_after_frame", 32'(irq), 32'd1);
    bus(0, 1, 0, 4'hf);
    bus(1, 1, 32'h0, 4'h1);
    idle(2);
    check("irq_disabled", 32'(irq), 32'd0);
`else
    bus(1, 1, 32'hFFFF_FFFF, 4'hf);        // STATUS write has no effect
    bus(0, 1, 0, 4'hf);
`endif
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) bus(1, 0, $urandom, 4'($urandom_range(0, 15)) | {3'b0, r < 5});
      else if (r < 8) bus(0, 1, 0, 4'hf);
      else if (r == 8) bus(0, 0, 0, 4'hf);
      else idle($urandom_range(0, 60));
    end
    drain();
    bus(1, 0, 32'h3C, 4'h1);
    bus(1, 0, 32'h5A, 4'h1);
    bus(1, 0, 32'h99, 4'h1);
    idle(2 * DIV);                         // now in the DATA phase of the first frame
    do_reset();
    bus(0, 1, 0, 4'hf);                    // flushed: empty, idle
    idle(3 * FRAME);                       // spurious frames would be caught by the line monitor
    check("tx_idle_end", 32'(tx), 32'd1);
    check("rdt_queue_empty", 32'(sb_rdt.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
